// File: rtl/logic_dispatch.sv
// logic_dispatch: issue and writeback front end for a fixed-latency pipelined logic unit.
// Reads operands from an internal register file, drives registered a/b/op to the unit,
// tracks its latency with a tag pipe and writes results back. A pending-write scoreboard
// stalls issue on RAW/WAW hazards against in-flight results.
// Optional build macro: LOGIC_DISPATCH_BYPASS_EN forwards the returning result to issue.
module logic_dispatch #(
  parameter int unsigned LAT  = 3,
  parameter int unsigned NREG = 8,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic [31:0]   lu_a,
  output logic [31:0]   lu_b,
  output logic [2:0]    lu_op,
  input  logic [31:0]   lu_out,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [31:0]   wb_data
);

  logic [NREG-1:0][31:0] rf_q, rf_d;
  logic [NREG-1:0]       pend_q, pend_d;
  logic [LAT:0]          tag_vld_q, tag_vld_d;
  logic [LAT:0][AW-1:0]  tag_rd_q, tag_rd_d;
  logic [31:0]           lu_a_q, lu_a_d;
  logic [31:0]           lu_b_q, lu_b_d;
  logic [2:0]            lu_op_q, lu_op_d;

  logic                  byp_rs1, byp_rs2, byp_rd;
  logic                  hazard;
  logic                  issue;
  logic [31:0]           opnd_a, opnd_b;

  // Last tag stage marks the returning result; masked during reset so nothing escapes.
  assign wb_valid = tag_vld_q[LAT] & ~rst;
  assign wb_rd    = tag_rd_q[LAT];
  assign wb_data  = wb_valid ? lu_out : '0;

  assign lu_a  = lu_a_q;
  assign lu_b  = lu_b_q;
  assign lu_op = lu_op_q;

  // Hazard check against the scoreboard and operand selection.
  always_comb begin
`ifdef LOGIC_DISPATCH_BYPASS_EN
    // A register whose result returns this cycle is resolved and taken from lu_out.
    byp_rs1 = wb_valid && (wb_rd == in_rs1);
    byp_rs2 = wb_valid && (wb_rd == in_rs2);
    byp_rd  = wb_valid && (wb_rd == in_rd);
`else
    byp_rs1 = 1'b0;
    byp_rs2 = 1'b0;
    byp_rd  = 1'b0;
`endif
    hazard = (pend_q[in_rs1] & ~byp_rs1) |
             (pend_q[in_rs2] & ~byp_rs2) |
             (pend_q[in_rd]  & ~byp_rd);
    opnd_a = byp_rs1 ? lu_out : rf_q[in_rs1];
    opnd_b = byp_rs2 ? lu_out : rf_q[in_rs2];
  end

  assign in_ready = ~rst & ~hazard;
  assign issue    = in_valid & in_ready;

  // Next-state for register file, scoreboard, tag pipe and unit operands.
  always_comb begin
    rf_d = rf_q;
    if (ld_en) begin
      rf_d[ld_addr] = ld_data;
    end
    // Writeback is applied after the load so it wins on an address collision.
    if (wb_valid) begin
      rf_d[wb_rd] = lu_out;
    end

    pend_d = pend_q;
    if (wb_valid) begin
      pend_d[wb_rd] = 1'b0;
    end
    // Set after clear: a reissue to the returning register stays pending.
    if (issue) begin
      pend_d[in_rd] = 1'b1;
    end

    tag_vld_d = {tag_vld_q[LAT-1:0], issue};
    tag_rd_d  = {tag_rd_q[LAT-1:0], in_rd};

    lu_a_d  = lu_a_q;
    lu_b_d  = lu_b_q;
    lu_op_d = lu_op_q;
    if (issue) begin
      lu_a_d  = opnd_a;
      lu_b_d  = opnd_b;
      lu_op_d = in_op;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q      <= '0;
      pend_q    <= '0;
      tag_vld_q <= '0;
      tag_rd_q  <= '0;
      lu_a_q    <= '0;
      lu_b_q    <= '0;
      lu_op_q   <= '0;
    end else begin
      rf_q      <= rf_d;
      pend_q    <= pend_d;
      tag_vld_q <= tag_vld_d;
      tag_rd_q  <= tag_rd_d;
      lu_a_q    <= lu_a_d;
      lu_b_q    <= lu_b_d;
      lu_op_q   <= lu_op_d;
    end
  end

endmodule

// File: tb/tb_logic_dispatch.sv
// Testbench for logic_dispatch: a stand-in logic unit plus a reference model that tracks
// in-flight instructions as a list with due cycles and a plain register array.
`timescale 1ns/1ps
module tb_logic_dispatch;

  localparam int unsigned LAT  = 3;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;
`ifdef LOGIC_DISPATCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [31:0]   lu_a, lu_b, lu_out;
  logic [2:0]    lu_op;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [31:0]   wb_data;

  logic_dispatch #(.LAT(LAT), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op), .lu_out(lu_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lu_fn(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    logic [31:0] r;
    case (op[2:1])
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = a;
    endcase
    return op[0] ? r : ~r;
  endfunction

  // Stand-in logic unit: captures a/b/op one edge after issue, result LAT edges after issue.
  logic [31:0] lu_pipe [LAT];
  always @(posedge clk) begin
    lu_pipe[0] <= lu_fn(lu_a, lu_b, lu_op);
    for (int i = 1; i < LAT; i++) lu_pipe[i] <= lu_pipe[i-1];
  end
  assign lu_out = lu_pipe[LAT-1];

  typedef struct {
    logic [AW-1:0] rd;
    logic [31:0]   data;
    int            due;
  } ent_t;

  typedef struct {
    logic [AW-1:0] rd;
    logic [31:0]   data;
    int            cyc;
  } obs_t;

  logic [31:0] mrf [NREG];
  ent_t        q[$];
  obs_t        obs[$];
  int          cyc = 0;
  int          last_due = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // One clock cycle: check outputs against the model, then advance the model across the edge.
  task automatic tick(output bit acc);
    logic          exp_rdy, exp_wv, now;
    logic [AW-1:0] exp_wrd;
    logic [31:0]   exp_wd, a, b;
    ent_t          keep[$];
    #1;
    exp_rdy = !rst;
    exp_wv  = 1'b0;
    exp_wrd = '0;
    exp_wd  = '0;
    a = mrf[in_rs1];
    b = mrf[in_rs2];
    foreach (q[i]) begin
      now = (q[i].due == cyc);
      if (now && !rst) begin
        exp_wv  = 1'b1;
        exp_wrd = q[i].rd;
        exp_wd  = q[i].data;
      end
      if (BYP && now) begin
        if (q[i].rd == in_rs1) a = q[i].data;
        if (q[i].rd == in_rs2) b = q[i].data;
      end else if (q[i].rd == in_rs1 || q[i].rd == in_rs2 || q[i].rd == in_rd) begin
        exp_rdy = 1'b0;
      end
    end

    n_checks++;
    if (in_ready !== exp_rdy)
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
    else n_pass++;
    n_checks++;
    if (wb_valid !== exp_wv)
      $display("FAIL wb_valid cyc=%0d got=%b exp=%b", cyc, wb_valid, exp_wv);
    else n_pass++;
    n_checks++;
    if (wb_data !== exp_wd)
      $display("FAIL wb_data cyc=%0d got=%h exp=%h", cyc, wb_data, exp_wd);
    else n_pass++;
    if (exp_wv) begin
      n_checks++;
      if (wb_rd !== exp_wrd)
        $display("FAIL wb_rd cyc=%0d got=%0d exp=%0d", cyc, wb_rd, exp_wrd);
      else n_pass++;
    end
    if (wb_valid === 1'b1) obs.push_back('{rd: wb_rd, data: wb_data, cyc: cyc});

    acc = in_valid && exp_rdy;
    if (rst) begin
      q.delete();
      foreach (mrf[i]) mrf[i] = '0;
    end else begin
      if (ld_en) mrf[ld_addr] = ld_data;
      foreach (q[i]) begin
        if (q[i].due == cyc) mrf[q[i].rd] = q[i].data;
        else keep.push_back(q[i]);
      end
      q = keep;
      if (acc) begin
        last_due = cyc + 1 + int'(LAT);
        q.push_back('{rd: in_rd, data: lu_fn(a, b, in_op), due: last_due});
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [31:0] data);
    bit acc;
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick(acc);
    ld_en   = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, output int stalls);
    bit acc;
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    stalls   = 0;
    acc      = 1'b0;
    while (!acc && stalls < 30) begin
      tick(acc);
      if (!acc) stalls++;
    end
    n_checks++;
    if (!acc) $display("FAIL issue_timeout got=stalled exp=accepted rd=%0d", rd);
    else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    while (q.size() > 0 && guard < 50) begin
      tick(acc);
      guard++;
    end
    n_checks++;
    if (q.size() > 0) $display("FAIL drain_timeout got=%0d exp=0 pending", q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b1;
    tick(acc);
    tick(acc);
    n_checks++;
    if ({lu_a, lu_b, lu_op} !== '0)
      $display("FAIL reset_lu got=%h/%h/%h exp=0", lu_a, lu_b, lu_op);
    else n_pass++;
    rst = 1'b0;
    tick(acc);
  endtask

  task automatic test_basic_ops();
    int st;
    logic [31:0] exp [4];
    logic [AW-1:0] erd [4];
    exp = '{32'h00F0_00F0, 32'hFF0F_FF0F, 32'hF0F0_F0F0, 32'h00F0_00F0};
    erd = '{3'd3, 3'd4, 3'd5, 3'd7};
    load(1, 32'hF0F0_F0F0);
    load(2, 32'h0FF0_0FF0);
    obs.delete();
    issue(3'b001, 1, 2, 3, st);
    drain();
    issue(3'b000, 1, 2, 4, st);
    issue(3'b111, 1, 2, 5, st);
    drain();
    issue(3'b111, 3, 0, 7, st);   // reads back rf[3]
    drain();
    n_checks++;
    if (obs.size() != 4) $display("FAIL basic_count got=%0d exp=4", obs.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      n_checks++;
      if (obs[i].data !== exp[i] || obs[i].rd !== erd[i])
        $display("FAIL basic_%0d got=r%0d:%h exp=r%0d:%h", i, obs[i].rd, obs[i].data,
                 erd[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int st [3];
    logic [31:0] exp [3];
    exp = '{32'hFFF0_FFF0, 32'hFF00_FF00, 32'h00F0_00F0};
    obs.delete();
    issue(3'b011, 1, 2, 3, st[0]);
    issue(3'b101, 1, 2, 4, st[1]);
    issue(3'b001, 1, 2, 5, st[2]);
    drain();
    n_checks++;
    if (st[0] + st[1] + st[2] != 0)
      $display("FAIL b2b_stalls got=%0d exp=0", st[0] + st[1] + st[2]);
    else n_pass++;
    n_checks++;
    if (obs.size() != 3) $display("FAIL b2b_count got=%0d exp=3", obs.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      n_checks++;
      if (obs[i].data !== exp[i] || obs[i].rd !== 3 + i || obs[i].cyc != obs[0].cyc + i)
        $display("FAIL b2b_%0d got=r%0d:%h@%0d exp=r%0d:%h@%0d", i, obs[i].rd, obs[i].data,
                 obs[i].cyc, 3 + i, exp[i], obs[0].cyc + i);
      else n_pass++;
    end
  endtask

  task automatic test_dependent();
    int st0, st1, exp_st;
    exp_st = BYP ? int'(LAT) : int'(LAT) + 1;
    obs.delete();
    issue(3'b011, 1, 2, 3, st0);
    issue(3'b101, 3, 1, 6, st1);
    drain();
    n_checks++;
    if (st1 != exp_st) $display("FAIL dep_stalls got=%0d exp=%0d", st1, exp_st);
    else n_pass++;
    n_checks++;
    if (obs.size() != 2 || obs[obs.size()-1].data !== 32'h0F00_0F00)
      $display("FAIL dep_data got=%0d:%h exp=2:0f000f00", obs.size(),
               obs.size() ? obs[obs.size()-1].data : 32'h0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit acc;
    int st;
    issue(3'b001, 1, 2, 3, st);
    issue(3'b011, 1, 2, 4, st);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    obs.delete();
    // Sources/destination that would be pending had reset not cleared the scoreboard.
    issue(3'b111, 3, 4, 4, st);
    n_checks++;
    if (st != 0) $display("FAIL rstmid_ready got=%0d exp=0 stalls", st);
    else n_pass++;
    drain();
    for (int i = 0; i < int'(LAT) + 2; i++) tick(acc);
    n_checks++;
    if (obs.size() != 1 || obs[0].data !== 32'h0 || obs[0].rd !== 3'd4)
      $display("FAIL rstmid_wb got=%0d wb exp=1 wb r4:0", obs.size());
    else n_pass++;
  endtask

  task automatic test_ld_collide();
    bit acc;
    int st;
    load(1, 32'hF0F0_F0F0);
    load(2, 32'h0FF0_0FF0);
    issue(3'b011, 1, 2, 3, st);
    while (cyc < last_due) tick(acc);
    ld_en   = 1'b1;
    ld_addr = 3;
    ld_data = 32'h1234_5678;
    tick(acc);
    ld_en = 1'b0;
    drain();
    obs.delete();
    issue(3'b111, 3, 0, 7, st);
    drain();
    n_checks++;
    if (obs.size() != 1 || obs[0].data !== 32'hFFF0_FFF0)
      $display("FAIL ld_collide got=%0d:%h exp=1:fff0fff0", obs.size(),
               obs.size() ? obs[0].data : 32'h0);
    else n_pass++;
  endtask

  task automatic test_random();
    bit acc;
    bit held = 1'b0;
    for (int r = 0; r < NREG; r++) load(r[AW-1:0], $urandom);
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_op    = 3'($urandom_range(0, 7));
        in_rs1   = AW'($urandom_range(0, NREG - 1));
        in_rs2   = AW'($urandom_range(0, NREG - 1));
        in_rd    = AW'($urandom_range(0, NREG - 1));
      end
      ld_en   = ($urandom_range(0, 9) == 0);
      ld_addr = AW'($urandom_range(0, NREG - 1));
      ld_data = $urandom;
      tick(acc);
      held = in_valid && !acc;
    end
    in_valid = 1'b0;
    ld_en    = 1'b0;
    drain();
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_op    = '0;
    in_rs1   = '0;
    in_rs2   = '0;
    in_rd    = '0;
    ld_en    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    test_reset();
    test_basic_ops();
    test_back_to_back();
    test_dependent();
    test_reset_mid();
    test_ld_collide();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/logic_dispatch.md
# logic_dispatch

Issue and writeback front end for the pipelined logic unit. It accepts logic instructions over a valid/ready handshake and reads operands from an internal register file. It drives registered `a`/`b`/`op` into the logic unit, tracks the unit's fixed latency with a tag pipe, and writes returning results back. A scoreboard stalls issue on RAW and WAW hazards against in-flight results.

## Interface
Parameters:
- `LAT`, 3: clock edges from the logic unit capturing its inputs to its `out` being valid.
- `NREG`, 8: register file depth; address width `AW = $clog2(NREG)`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  instruction accepted this edge when `in_valid & in_ready`.
- `in_op`  in  3  logic op, passed through to the logic unit.
- `in_rs1`, `in_rs2`, `in_rd`  in  AW  source and destination registers.
- `ld_en`, `ld_addr` [AW], `ld_data` [32]  in  direct register-file load port (initialisation).
- `lu_a`, `lu_b`  out  32  registered operands to the logic unit.
- `lu_op`  out  3  registered op to the logic unit.
- `lu_out`  in  32  logic unit result.
- `wb_valid`  out  1  result returning this cycle.
- `wb_rd`  out  AW  destination of the returning result.
- `wb_data`  out  32  equals `lu_out` when `wb_valid`, else 0.

## Operation
- Op encoding:
  - `op[2:1]`: 00 AND, 01 OR, 10 XOR, 11 pass `a`.
  - `op[0]`: 1 true result, 0 bitwise complement.
- Scoreboard: `pend[NREG]`.
  - Set for `rd` at issue.
  - Cleared at writeback.
  - If the same register is both issued and written back in the same cycle, set wins.
- Hazard: `pend[rs1] | pend[rs2] | pend[rd]`.
- `in_ready = ~rst & ~hazard`. It is combinational from `in_rs*`/`in_rd` and state.
- Issue edge:
  - `lu_a <= rf[rs1]`, `lu_b <= rf[rs2]`, `lu_op <= in_op`.
  - Tag `{1, rd}` enters tag pipe stage 0.
- Idle edges: `lu_*` hold their values; tag stage 0 gets valid 0.
- Tag pipe: LAT+1 stages, shifts every edge. Stage LAT drives `wb_valid`/`wb_rd` combinationally.
- Writeback edge: `rf[wb_rd] <= lu_out`, `pend[wb_rd]` cleared.
- `ld_en` writes `rf[ld_addr]` and does not touch `pend`.
  - Writeback to the same address on the same edge wins over `ld_en`.
- Reset:
  - `pend`, all tag valids, `lu_a`, `lu_b`, `lu_op` and `rf` clear to 0.
  - `in_ready` = 0 while `rst` is high; `wb_valid` = 0, `wb_data` = 0.
- Reset mid-operation: in-flight results are discarded. The logic unit has no reset, so its `out` is ignored because all tags are invalid.

## Timing
- Issue at edge E0:
  - `lu_*` valid after E0; the logic unit captures at E1; `lu_out` is valid after E0+LAT.
  - `wb_valid` is high in the cycle between E0+LAT and E0+LAT+1; `rf` is written at E0+LAT+1.
- Throughput: one issue per cycle when there are no hazards.
- Dependent instruction (source = previous `rd`) issued at E0:
  - Earliest issue without bypass: E0+LAT+2.
  - Earliest issue with bypass: E0+LAT+1.
- Stall: `in_*` must be held stable by the sender while `in_valid & ~in_ready`.

## Configuration
- `LOGIC_DISPATCH_BYPASS_EN` defined:
  - A source or destination whose `pend` bit is being cleared this cycle (`wb_valid & wb_rd == rs/rd`) does not count as a hazard.
  - The matching operand is taken from `lu_out` instead of `rf`.
- `LOGIC_DISPATCH_BYPASS_EN` undefined: no bypass; the hazard persists until the edge that clears `pend`.

## Test plan
- Reset, then load r1=0xF0F0_F0F0 and r2=0x0FF0_0FF0. Issue AND (op=001) r3←r1,r2 at E0 -> `wb_valid` in cycle E0+3..E0+4, `wb_rd`=3, `wb_data`=0x00F0_00F0, rf[3] updated.
- Issue op=000 (NAND) r4←r1,r2 -> `wb_data`=0xFF0F_FF0F. Issue op=111 r5←r1,r2 (pass `a`) -> 0xF0F0_F0F0.
- Back-to-back independent OR→r3, XOR→r4, AND→r5 on consecutive edges -> `in_ready` held 1; three consecutive `wb_valid` cycles in order, with 0xFFF0_FFF0, 0xFF00_FF00, 0x00F0_00F0.
- Dependent XOR r6←r3,r1 right after r3←r1|r2 -> `in_ready`=0 until issue at E0+5 (no bypass) or E0+4 (bypass). In both builds `wb_data`=0x0F00_0F00.
- Assert `rst` one cycle after issuing two instructions -> no `wb_valid` ever appears; `pend` clear, so `in_ready`=1 immediately after reset deasserts; rf reads 0.
- `ld_en` to r3 on the same edge as r3 writeback -> rf[3] holds the writeback value.
